// File: rtl/states_pkg.sv
// rtl/states_pkg.sv - shared FSM state types
// Purpose: state encodings shared by blocks in the UART subsystem.
// Ports: none (package).
package states_pkg;

    // Transmit arbiter: pick an owner, stream its bytes, then one idle turnaround cycle.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_XFER = 2'd1,
        ARB_GAP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin requester search
// Purpose: returns the first set bit of req, searching upward from rr_ptr
//          and wrapping modulo N_REQ.
// Ports:
//   req    - request vector, one bit per requester
//   rr_ptr - index where the search starts
//   pick   - one-hot selected requester, all zeros when req is zero
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    rr_ptr,
    output logic [N_REQ-1:0] pick
);

    logic [PW:0] idx;
    logic        found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // One extra bit so rr_ptr + i cannot overflow before the wrap.
            idx = {1'b0, rr_ptr} + (PW + 1)'(i);
            if (idx >= (PW + 1)'(N_REQ)) begin
                idx = idx - (PW + 1)'(N_REQ);
            end
            if (!found && req[idx[PW-1:0]]) begin
                pick[idx[PW-1:0]] = 1'b1;
                found             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter feeding byte streams into the UART TX FIFO
// Purpose: grants one requester at a time and forwards its bytes to the TX FIFO
//          until req_last, a burst limit of MAX_BURST bytes, or the owner drops req.
// Ports:
//   clk, rst  - clock; asynchronous active-high reset
//   req       - per-requester byte-available flags
//   req_data  - per-requester bytes, requester i at [i*DBIT +: DBIT]
//   req_last  - per-requester end-of-message flags
//   req_ack   - one-hot byte-consumed strobe
//   grant     - one-hot current owner, or zero
//   w_data    - byte to TX FIFO
//   wr_uart   - TX FIFO write strobe
//   tx_full   - TX FIFO full flag
//   trunc     - pulse when a grant ends without req_last
//   busy      - arbiter not idle
module uart_tx_arbiter
    import states_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DBIT      = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*DBIT-1:0] req_data,
    input  logic [N_REQ-1:0]      req_last,
    output logic [N_REQ-1:0]      req_ack,
    output logic [N_REQ-1:0]      grant,
    output logic [DBIT-1:0]       w_data,
    output logic                  wr_uart,
    input  logic                  tx_full,
    output logic                  trunc,
    output logic                  busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [N_REQ-1:0] pick;
    logic             own_req;
    logic             own_last;
    logic [DBIT-1:0]  own_data;
    logic [PW-1:0]    next_ptr;

    rr_picker #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .pick   (pick)
    );

    // Owner signals are muxed with the one-hot grant so no binary index is
    // needed on the data path; next_ptr is the owner index plus one, wrapped.
    always_comb begin
        own_req  = |(req & grant_q);
        own_last = |(req_last & grant_q);
        own_data = '0;
        next_ptr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                own_data = own_data | req_data[i*DBIT +: DBIT];
                next_ptr = (i == N_REQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        wr_uart  = 1'b0;
        req_ack  = '0;
        w_data   = '0;
        trunc    = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (|req) begin
                    grant_d = pick;
                    cnt_d   = '0;
                    state_d = ARB_XFER;
                end else begin
                    grant_d = '0;
                end
            end

            ARB_XFER: begin
                w_data = own_data;
                if (!own_req) begin
                    // Owner went away mid-message: give up the grant with no write.
                    trunc    = 1'b1;
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                    state_d  = ARB_GAP;
                end else if (!tx_full) begin
                    wr_uart = 1'b1;
                    req_ack = grant_q;
                    cnt_d   = cnt_q + CW'(1);
                    if (own_last) begin
                        grant_d  = '0;
                        rr_ptr_d = next_ptr;
                        state_d  = ARB_GAP;
                    end else if (cnt_q == CW'(MAX_BURST - 1)) begin
                        // Burst limit reached on this byte; the rest of the
                        // message must win a fresh grant.
                        trunc    = 1'b1;
                        grant_d  = '0;
                        rr_ptr_d = next_ptr;
                        state_d  = ARB_GAP;
                    end
                end
                // tx_full with owner still requesting: hold everything.
            end

            ARB_GAP: begin
                grant_d = '0;
                state_d = ARB_IDLE;
            end

            default: begin
                grant_d = '0;
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign grant = grant_q;
    assign busy  = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DB = 8;
    localparam int MB = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, req_last, req_ack, grant;
    logic [N*DB-1:0] req_data;
    logic [DB-1:0]   w_data;
    logic            wr_uart, tx_full, trunc, busy;

    uart_tx_arbiter #(.N_REQ(N), .DBIT(DB), .MAX_BURST(MB)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .req_ack  (req_ack),
        .grant    (grant),
        .w_data   (w_data),
        .wr_uart  (wr_uart),
        .tx_full  (tx_full),
        .trunc    (trunc),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] src_q  [N][$];
    bit         src_last[N][$];
    logic [7:0] exp_q  [N][$];

    logic          s_wr, s_trunc, s_busy;
    logic [N-1:0]  s_ack, s_grant;
    logic [DB-1:0] s_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int i, input int n, input logic [7:0] base, input bit last_at_end);
        for (int k = 0; k < n; k++) begin
            src_q[i].push_back(8'(int'(base) + k));
            src_last[i].push_back(last_at_end && (k == n - 1));
            exp_q[i].push_back(8'(int'(base) + k));
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i]               = (src_q[i].size() > 0);
            req_data[i*DB +: DB] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
            req_last[i]          = (src_q[i].size() > 0) ? src_last[i][0] : 1'b0;
        end
    endtask

    // One clock: drive requesters, sample at negedge, score writes, consume acked bytes.
    task automatic tick();
        int id;
        logic [7:0] e;
        drive();
        @(negedge clk);
        s_wr = wr_uart; s_ack = req_ack; s_grant = grant;
        s_trunc = trunc; s_busy = busy; s_wdata = w_data;
        if (s_wr) begin
            id = -1;
            for (int i = 0; i < N; i++) if (s_ack[i]) id = i;
            chk("ack_eq_grant", 32'(s_ack), 32'(s_grant));
            chk("sb_has_expected", 32'((id >= 0) && (exp_q[id].size() > 0)), 32'd1);
            if (id >= 0 && exp_q[id].size() > 0) begin
                e = exp_q[id].pop_front();
                chk("sb_data", 32'(s_wdata), 32'(e));
            end
        end
        for (int i = 0; i < N; i++) begin
            if (s_ack[i] && src_q[i].size() > 0) begin
                void'(src_q[i].pop_front());
                void'(src_last[i].pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic int pending();
        int t = 0;
        for (int i = 0; i < N; i++) t += src_q[i].size();
        return t;
    endfunction

    task automatic drain(input string tag, input int max);
        int k = 0;
        while ((pending() > 0 || busy) && k < max) begin
            tick();
            k++;
        end
        chk({tag, "_drain_in_time"}, 32'(k < max), 32'd1);
        for (int i = 0; i < N; i++) chk({tag, "_exp_empty"}, 32'(exp_q[i].size()), 32'd0);
    endtask

    task automatic wait_wr(input string tag, input int max);
        int k = 0;
        s_wr = 1'b0;
        while (!s_wr && k < max) begin
            tick();
            k++;
        end
        chk({tag, "_wr_seen"}, 32'(s_wr), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic         t_wr[6], t_busy[6], t_trunc[6];
    logic [N-1:0] t_grant[6];
    int           wcyc[$], wid[$];
    int           nw, k;

    initial begin
        // Reset state, with requests and data presented during reset.
        rst = 1'b1; tx_full = 1'b0;
        req = '1; req_last = '1; req_data = {N*DB{1'b1}};
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_wr", 32'(wr_uart), 32'd0);
        chk("rst_ack", 32'(req_ack), 32'd0);
        chk("rst_wdata", 32'(w_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_trunc", 32'(trunc), 32'd0);
        req = '0; req_last = '0; req_data = '0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Single requester, three bytes with last on the third.
        load(0, 3, 8'h41, 1'b1);
        for (int c = 0; c < 6; c++) begin
            tick();
            t_wr[c] = s_wr; t_busy[c] = s_busy; t_trunc[c] = s_trunc; t_grant[c] = s_grant;
        end
        chk("single_c0_wr", 32'(t_wr[0]), 32'd0);
        chk("single_c0_busy", 32'(t_busy[0]), 32'd0);
        for (int c = 1; c <= 3; c++) begin
            chk("single_xfer_wr", 32'(t_wr[c]), 32'd1);
            chk("single_xfer_grant", 32'(t_grant[c]), 32'b0001);
            chk("single_xfer_trunc", 32'(t_trunc[c]), 32'd0);
        end
        chk("single_gap_busy", 32'(t_busy[4]), 32'd1);
        chk("single_gap_grant", 32'(t_grant[4]), 32'd0);
        chk("single_gap_wr", 32'(t_wr[4]), 32'd0);
        chk("single_idle_busy", 32'(t_busy[5]), 32'd0);
        drain("single", 10);

        // Round-robin fairness from rr_ptr = 0, single-byte messages.
        do_reset();
        for (int i = 0; i < N; i++) begin
            load(i, 1, 8'h10 + 8'(i), 1'b1);
            load(i, 1, 8'h20 + 8'(i), 1'b1);
        end
        for (int c = 0; c < 14; c++) begin
            tick();
            if (s_wr) begin
                wcyc.push_back(c);
                for (int i = 0; i < N; i++) if (s_grant[i]) wid.push_back(i);
            end
        end
        chk("rr_write_count", 32'(wcyc.size() >= 5), 32'd1);
        if (wcyc.size() >= 5 && wid.size() >= 5) begin
            for (int j = 0; j < 5; j++) begin
                chk("rr_order", 32'(wid[j]), 32'(j % N));
                if (j > 0) chk("rr_spacing", 32'(wcyc[j] - wcyc[j-1]), 32'd3);
            end
        end
        drain("rr", 40);

        // Backpressure: tx_full held for 5 cycles mid-message.
        load(2, 4, 8'hA0, 1'b1);
        wait_wr("bp", 8);
        tx_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_no_wr", 32'(s_wr), 32'd0);
            chk("bp_no_ack", 32'(s_ack), 32'd0);
            chk("bp_grant_held", 32'(s_grant), 32'b0100);
        end
        tx_full = 1'b0;
        tick();
        chk("bp_resume_wr", 32'(s_wr), 32'd1);
        chk("bp_resume_grant", 32'(s_grant), 32'b0100);
        drain("bp", 20);

        // Burst limit: 20 bytes without last from requester 1.
        load(1, 20, 8'h00, 1'b0);
        nw = 0; k = 0; s_trunc = 1'b0;
        while (!s_trunc && k < 40) begin
            tick();
            if (s_wr) nw++;
            k++;
        end
        chk("burst_trunc_seen", 32'(s_trunc), 32'd1);
        chk("burst_count", 32'(nw), 32'(MB));
        chk("burst_trunc_on_write", 32'(s_wr), 32'd1);
        tick();
        chk("burst_gap_busy", 32'(s_busy), 32'd1);
        chk("burst_gap_grant", 32'(s_grant), 32'd0);
        tick();
        chk("burst_idle_busy", 32'(s_busy), 32'd0);
        tick();
        chk("burst_regrant", 32'(s_grant), 32'b0010);
        chk("burst_regrant_wr", 32'(s_wr), 32'd1);
        drain("burst", 20);

        // Abort: requester 3 drops req after 2 bytes; requester 0 is next.
        load(3, 2, 8'hC0, 1'b0);
        load(0, 1, 8'hD0, 1'b1);
        nw = 0; k = 0; s_trunc = 1'b0;
        while (!s_trunc && k < 20) begin
            tick();
            if (s_wr && s_grant == 4'b1000) nw++;
            k++;
        end
        chk("abort_trunc_seen", 32'(s_trunc), 32'd1);
        chk("abort_bytes", 32'(nw), 32'd2);
        chk("abort_no_wr", 32'(s_wr), 32'd0);
        wait_wr("abort_next", 5);
        chk("abort_next_grant", 32'(s_grant), 32'b0001);
        drain("abort", 10);

        // Asynchronous reset mid-transfer; rr_ptr is 1 before it.
        load(1, 5, 8'hE0, 1'b1);
        wait_wr("arst", 8);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_wr", 32'(wr_uart), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ack", 32'(req_ack), 32'd0);
        src_q[1].delete(); src_last[1].delete(); exp_q[1].delete();
        @(posedge clk);
        #3 rst = 1'b0;
        for (int i = 0; i < N; i++) load(i, 1, 8'hF0 + 8'(i), 1'b1);
        wait_wr("arst_after", 6);
        chk("arst_first_grant", 32'(s_grant), 32'b0001);
        drain("arst", 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
